// File: rtl/dmem_responder_pkg.sv
// Shared types, state encodings and fault check for the MEM-stage data memory responder.
package dmem_responder_pkg;

  typedef logic [31:0] data_addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  byte_sel_t;

  localparam logic RSTN_ENABLE = 1'b0;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dm_state_e;

  // Misaligned, empty lane mask, or beyond the array: answered with err and no access.
  function automatic logic req_fault(data_addr_t addr, byte_sel_t sel, int unsigned depth_log2);
    return (addr[1:0] != 2'b00) || (sel == 4'b0000) || ((addr >> (depth_log2 + 2)) != '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-lane byte writes and a registered read port.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  data_t mem [2**DEPTH_LOG2];

  // we[3] is lane 31:24, matching the big-endian select order of the core.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (we[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      rdata <= mem[waddr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: accepts a MEM-stage request, waits WAIT_CYCLES, accesses the array, acks for one cycle.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_o
);

  dm_state_e             state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [DEPTH_LOG2-1:0] word_q, word_d;
  byte_sel_t             sel_q, sel_d;
  data_t                 wdata_q, wdata_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  rd_valid_q, rd_valid_d;

  logic                  acc_en;
  logic [3:0]            acc_we;
  logic [DEPTH_LOG2-1:0] acc_word;
  data_t                 acc_wdata;
  logic                  ram_en;
  data_t                 ram_rdata;
  logic                  fault;

  assign fault = req_fault(addr_i, sel_i, DEPTH_LOG2);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    word_d     = word_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rd_valid_d = 1'b0;
    acc_en     = 1'b0;
    acc_we     = '0;
    acc_word   = word_q;
    acc_wdata  = wdata_q;

    unique case (state_q)
      DM_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          word_d  = addr_i[DEPTH_LOG2+1:2];
          sel_d   = sel_i;
          wdata_d = wdata_i;
          cnt_d   = 3'(WAIT_CYCLES);
          if (fault) begin
            state_d = DM_RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            // Zero wait states: access straight from the request inputs at acceptance.
            state_d    = DM_RESP;
            ack_d      = 1'b1;
            rd_valid_d = ~we_i;
            acc_en     = 1'b1;
            acc_we     = we_i ? sel_i : 4'b0000;
            acc_word   = addr_i[DEPTH_LOG2+1:2];
            acc_wdata  = wdata_i;
          end else begin
            state_d = DM_WAIT;
          end
        end
      end
      DM_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d    = DM_RESP;
          ack_d      = 1'b1;
          rd_valid_d = ~we_q;
          acc_en     = 1'b1;
          acc_we     = we_q ? sel_q : 4'b0000;
        end
      end
      DM_RESP: state_d = DM_IDLE;
      default: state_d = DM_IDLE;
    endcase
  end

  // A held reset must never let a pending store reach the array.
  assign ram_en = acc_en & (rst != RSTN_ENABLE);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTN_ENABLE) begin
      state_q    <= DM_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      word_q     <= '0;
      sel_q      <= '0;
      wdata_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      word_q     <= word_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .en   (ram_en),
    .we   (acc_we),
    .waddr(acc_word),
    .wdata(acc_wdata),
    .rdata(ram_rdata)
  );

  // Array read register supplies the data; a reset flop zeroes it for stores, faults and idle.
  assign rdata_o = rd_valid_q ? ram_rdata : '0;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign stall_o = req_i & ~ack_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances with WAIT_CYCLES 1, 0 and 3 sharing clock and reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req, we, ack, err, stall;
  logic [31:0] addr [3];
  logic [31:0] wdata[3];
  logic [31:0] rdata[3];
  logic [3:0]  sel  [3];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          inst;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]), .sel_i(sel[0]),
    .wdata_i(wdata[0]), .rdata_o(rdata[0]), .ack_o(ack[0]), .err_o(err[0]), .stall_o(stall[0]));
  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]), .sel_i(sel[1]),
    .wdata_i(wdata[1]), .rdata_o(rdata[1]), .ack_o(ack[1]), .err_o(err[1]), .stall_o(stall[1]));
  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .req_i(req[2]), .we_i(we[2]), .addr_i(addr[2]), .sel_i(sel[2]),
    .wdata_i(wdata[2]), .rdata_o(rdata[2]), .ack_o(ack[2]), .err_o(err[2]), .stall_o(stall[2]));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(int inst, logic w, logic [31:0] a, logic [3:0] s, logic [31:0] d);
    req[inst]   = 1'b1;
    we[inst]    = w;
    addr[inst]  = a;
    sel[inst]   = s;
    wdata[inst] = d;
  endtask

  task automatic push_exp(int inst, logic [31:0] r, logic e, int lat);
    exp_t x;
    x.inst = inst; x.rdata = r; x.err = e; x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic pop_check(int inst, int lat);
    exp_t x;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard: ack on inst %0d with no expected entry", inst);
      return;
    end
    x = sb.pop_front();
    chk($sformatf("inst%0d owner", inst), 32'(inst), 32'(x.inst));
    chk($sformatf("inst%0d rdata", inst), rdata[inst], x.rdata);
    chk($sformatf("inst%0d err", inst), 32'(err[inst]), 32'(x.err));
    chk($sformatf("inst%0d latency", inst), 32'(lat), 32'(x.lat));
  endtask

  // Caller sits at a negedge; 'elapsed' edges have already passed since acceptance.
  task automatic wait_ack(int inst, int elapsed);
    int n = elapsed;
    bit seen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (ack[inst]) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL inst%0d ack timeout: no ack within 32 cycles", inst);
      void'(sb.pop_front());
      req[inst] = 1'b0;
      return;
    end
    pop_check(inst, n);
    req[inst] = 1'b0;
    @(negedge clk);
    chk($sformatf("inst%0d ack width", inst), 32'(ack[inst]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0; we = '0;
    for (int i = 0; i < 3; i++) begin addr[i] = '0; wdata[i] = '0; sel[i] = '0; end

    // {inst, we, addr, sel, wdata, exp_rdata, exp_err, exp_lat}
    tbl.push_back('{0, 1'b1, 32'h10,   4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 2});
    tbl.push_back('{0, 1'b0, 32'h10,   4'hF, 32'h0,        32'hDEADBEEF, 1'b0, 2});
    tbl.push_back('{0, 1'b1, 32'h10,   4'h4, 32'h00AA0000, 32'h0,        1'b0, 2});
    tbl.push_back('{0, 1'b0, 32'h10,   4'hF, 32'h0,        32'hDEAABEEF, 1'b0, 2});
    tbl.push_back('{0, 1'b0, 32'h12,   4'hF, 32'h0,        32'h0,        1'b1, 1});
    tbl.push_back('{0, 1'b1, 32'h0,    4'hF, 32'h12345678, 32'h0,        1'b0, 2});
    tbl.push_back('{0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b1, 1});
    tbl.push_back('{0, 1'b0, 32'h0,    4'hF, 32'h0,        32'h12345678, 1'b0, 2});
    tbl.push_back('{0, 1'b0, 32'h10,   4'h0, 32'h0,        32'h0,        1'b1, 1});
    tbl.push_back('{0, 1'b1, 32'hFFC,  4'hF, 32'h11223344, 32'h0,        1'b0, 2});
    tbl.push_back('{0, 1'b1, 32'hFFC,  4'h1, 32'hA5A5A5A5, 32'h0,        1'b0, 2});
    tbl.push_back('{0, 1'b0, 32'hFFC,  4'hF, 32'h0,        32'h112233A5, 1'b0, 2});
    tbl.push_back('{0, 1'b1, 32'h10,   4'h8, 32'h77000000, 32'h0,        1'b0, 2});
    tbl.push_back('{0, 1'b0, 32'h10,   4'hF, 32'h0,        32'h77AABEEF, 1'b0, 2});
    tbl.push_back('{1, 1'b1, 32'h20,   4'hF, 32'hCAFEF00D, 32'h0,        1'b0, 1});
    tbl.push_back('{1, 1'b1, 32'h24,   4'hF, 32'h0BADC0DE, 32'h0,        1'b0, 1});
    tbl.push_back('{1, 1'b0, 32'h26,   4'hF, 32'h0,        32'h0,        1'b1, 1});
    tbl.push_back('{2, 1'b1, 32'h40,   4'hF, 32'h55667788, 32'h0,        1'b0, 4});
    tbl.push_back('{2, 1'b1, 32'h48,   4'hF, 32'h99999999, 32'h0,        1'b0, 4});
    tbl.push_back('{2, 1'b0, 32'h40,   4'hF, 32'h0,        32'h55667788, 1'b0, 4});
    tbl.push_back('{2, 1'b0, 32'h12,   4'hF, 32'h0,        32'h0,        1'b1, 1});

    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset ack%0d", i), 32'(ack[i]), 32'd0);
      chk($sformatf("reset err%0d", i), 32'(err[i]), 32'd0);
      chk($sformatf("reset rdata%0d", i), rdata[i], 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      drive_req(tbl[i].inst, tbl[i].we, tbl[i].addr, tbl[i].sel, tbl[i].wdata);
      push_exp(tbl[i].inst, tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].exp_lat);
      wait_ack(tbl[i].inst, 0);
    end

    // Zero wait states, req held across two loads.
    drive_req(1, 1'b0, 32'h20, 4'hF, 32'h0);
    push_exp(1, 32'hCAFEF00D, 1'b0, 1);
    #1 chk("b2b stall k", 32'(stall[1]), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("b2b ack k+1", 32'(ack[1]), 32'd1);
    chk("b2b stall k+1", 32'(stall[1]), 32'd0);
    pop_check(1, 1);
    addr[1] = 32'h24;
    push_exp(1, 32'h0BADC0DE, 1'b0, 1);
    @(posedge clk); @(negedge clk);
    chk("b2b ack k+2", 32'(ack[1]), 32'd0);
    chk("b2b stall k+2", 32'(stall[1]), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("b2b ack k+3", 32'(ack[1]), 32'd1);
    pop_check(1, 1);
    req[1] = 1'b0;
    @(negedge clk);

    // Reset one cycle after a WAIT_CYCLES=3 store is accepted.
    drive_req(2, 1'b1, 32'h40, 4'hF, 32'hFFFFFFFF);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst ack", 32'(ack[2]), 32'd0);
    chk("midrst err", 32'(err[2]), 32'd0);
    chk("midrst rdata", rdata[2], 32'd0);
    req[2] = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    drive_req(2, 1'b0, 32'h40, 4'hF, 32'h0);
    push_exp(2, 32'h55667788, 1'b0, 4);
    wait_ack(2, 0);

    // Change addr/wdata while the store waits; the latched values must be used.
    drive_req(2, 1'b1, 32'h44, 4'hF, 32'h01020304);
    push_exp(2, 32'h0, 1'b0, 4);
    @(posedge clk); @(negedge clk);
    addr[2]  = 32'h48;
    wdata[2] = 32'hFFFFFFFF;
    wait_ack(2, 1);
    drive_req(2, 1'b0, 32'h44, 4'hF, 32'h0);
    push_exp(2, 32'h01020304, 1'b0, 4);
    wait_ack(2, 0);
    drive_req(2, 1'b0, 32'h48, 4'hF, 32'h0);
    push_exp(2, 32'h99999999, 1'b0, 4);
    wait_ack(2, 0);

    // Reset asserted during the ack cycle clears the registered outputs at once.
    drive_req(0, 1'b0, 32'h10, 4'hF, 32'h0);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("resp ack", 32'(ack[0]), 32'd1);
    chk("resp rdata", rdata[0], 32'h77AABEEF);
    rst = 1'b0;
    #1;
    chk("resp-rst ack", 32'(ack[0]), 32'd0);
    chk("resp-rst rdata", rdata[0], 32'd0);
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
